// File: rtl/pipe_hazard_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// sequencing controller (slave): hazard inputs one way, stage enables back.
interface pipe_hazard_if #(parameter int CNT_W = 16);
  logic [3:0]       id_rs_adress;
  logic [3:0]       id_rt_adress;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             ex_valid;
  logic [3:0]       ex_regC_adress;
  logic             ex_mem_read;
  logic             ex_write_inst;
  logic [5:0]       ex_alu_op;
  logic             branch_taken;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_write;
  logic             id_ex_bubble;
  logic             mc_busy;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs_adress, id_rt_adress, id_uses_rs, id_uses_rt, ex_valid,
           ex_regC_adress, ex_mem_read, ex_write_inst, ex_alu_op, branch_taken,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
           mc_busy, stall_count, flush_count
  );

  modport slave (
    input  id_rs_adress, id_rt_adress, id_uses_rs, id_uses_rt, ex_valid,
           ex_regC_adress, ex_mem_read, ex_write_inst, ex_alu_op, branch_taken,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
           mc_busy, stall_count, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stage enable / flush / bubble sequencing for the 5-stage core: load-use
// stall, taken-branch flush, counted EX freeze for MUL/DIV, saturating stats.
module pipe_hazard_ctrl #(
  parameter int          MC_CYCLES = 4,
  parameter logic [5:0]  MUL_OP    = 6'd24,
  parameter logic [5:0]  DIV_OP    = 6'd25,
  parameter int          CNT_W     = 16
) (
  input logic         clk,
  input logic         rst_n,
  pipe_hazard_if.slave hz
);

  typedef enum logic {RUN, MC_BUSY} state_t;

  // The entry cycle in RUN is the first of the MC_CYCLES, and the final
  // MC_BUSY cycle (count 0) releases the pipe, hence the -2.
  localparam logic [3:0] MC_LOAD = 4'(MC_CYCLES - 2);

  state_t     state;
  logic [3:0] mc_cnt;
  logic       load_use, mc_op;
  logic       pc_w, ifid_w, ifid_f, idex_w, idex_b;
  logic       br_acc, mc_start;

  assign load_use = hz.ex_valid & hz.ex_mem_read & hz.ex_write_inst &
                    ((hz.id_uses_rs & (hz.id_rs_adress == hz.ex_regC_adress)) |
                     (hz.id_uses_rt & (hz.id_rt_adress == hz.ex_regC_adress)));
  assign mc_op    = hz.ex_valid & ((hz.ex_alu_op == MUL_OP) | (hz.ex_alu_op == DIV_OP));

  always_comb begin
    pc_w     = 1'b1;
    ifid_w   = 1'b1;
    ifid_f   = 1'b0;
    idex_w   = 1'b1;
    idex_b   = 1'b0;
    br_acc   = 1'b0;
    mc_start = 1'b0;
    if (!rst_n) begin
      pc_w   = 1'b0;
      ifid_w = 1'b0;
      idex_w = 1'b0;
      ifid_f = 1'b1;
      idex_b = 1'b1;
    end else if (state == MC_BUSY) begin
      if (mc_cnt != 4'd0) begin
        pc_w   = 1'b0;
        ifid_w = 1'b0;
        idex_w = 1'b0;
      end
    end else if (hz.branch_taken) begin
      // The load-use dependent sits in IF/ID and is flushed anyway.
      ifid_f = 1'b1;
      idex_b = 1'b1;
      br_acc = 1'b1;
    end else if (mc_op) begin
      pc_w     = 1'b0;
      ifid_w   = 1'b0;
      idex_w   = 1'b0;
      mc_start = 1'b1;
    end else if (load_use) begin
      pc_w   = 1'b0;
      ifid_w = 1'b0;
      idex_b = 1'b1;
    end
  end

  assign hz.pc_write     = pc_w;
  assign hz.if_id_write  = ifid_w;
  assign hz.if_id_flush  = ifid_f;
  assign hz.id_ex_write  = idex_w;
  assign hz.id_ex_bubble = idex_b;
  assign hz.mc_busy      = rst_n & (state == MC_BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      mc_cnt         <= 4'd0;
      hz.stall_count <= '0;
      hz.flush_count <= '0;
    end else begin
      if (!pc_w && !(&hz.stall_count)) hz.stall_count <= hz.stall_count + 1'b1;
      if (br_acc && !(&hz.flush_count)) hz.flush_count <= hz.flush_count + 1'b1;
      case (state)
        RUN: if (mc_start) begin
          state  <= MC_BUSY;
          mc_cnt <= MC_LOAD;
        end
        MC_BUSY: begin
          if (mc_cnt == 4'd0) state <= RUN;
          else                mc_cnt <= mc_cnt - 4'd1;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage 32-bit core. It produces the write-enable, flush and bubble controls for the PC, the IF/ID register and the ID/EX register.
- Resolves load-use hazards with a one-cycle stall.
- Resolves taken branches with a two-stage flush.
- Resolves multi-cycle ALU operations (MUL/DIV) with a counted EX freeze.
- Keeps saturating stall and flush statistics counters.

Parameters:
MC_CYCLES, 4, total cycles a multi-cycle op occupies EX; legal range 2..15
MUL_OP, 6'd24, alu op code treated as multi-cycle
DIV_OP, 6'd25, alu op code treated as multi-cycle
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
id_rs_adress  in  4  source register A of the instruction in IF/ID
id_rt_adress  in  4  source register B of the instruction in IF/ID
id_uses_rs  in  1  IF/ID instruction reads rs
id_uses_rt  in  1  IF/ID instruction reads rt
ex_valid  in  1  ID/EX holds a real instruction (0 for a bubble)
ex_regC_adress  in  4  destination register held in ID/EX
ex_mem_read  in  1  ID/EX instruction is a load
ex_write_inst  in  1  ID/EX instruction writes the register bank
ex_alu_op  in  6  alu op held in ID/EX
branch_taken  in  1  EX resolved a taken branch this cycle
pc_write  out  1  PC load enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID loads zeros (takes effect only when if_id_write=1)
id_ex_write  out  1  ID/EX load enable
id_ex_bubble  out  1  ID/EX loads zeros with ex_valid=0
mc_busy  out  1  multi-cycle op in progress (state MC_BUSY)
stall_count  out  CNT_W  saturating count of cycles with pc_write=0
flush_count  out  CNT_W  saturating count of taken-branch flushes

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- While rst_n=0:
  - state=RUN, counter=0, stall_count=0, flush_count=0.
  - Outputs forced to: pc_write=0, if_id_write=0, id_ex_write=0, if_id_flush=1, id_ex_bubble=1, mc_busy=0.
- After rst_n rises, outputs are combinational from state and inputs, following the rules below.
- States and internal counter: two states, RUN and MC_BUSY. A 4-bit down-counter mc_cnt.
- Hazard definitions:
  - load_use = ex_valid & ex_mem_read & ex_write_inst & ((id_uses_rs & id_rs_adress==ex_regC_adress) | (id_uses_rt & id_rt_adress==ex_regC_adress)). Register 0 is not special.
  - mc_op = ex_valid & (ex_alu_op==MUL_OP | ex_alu_op==DIV_OP).
- RUN, evaluated in priority order:
  1. branch_taken=1: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_write=1, id_ex_bubble=1. load_use is ignored because the dependent instruction is flushed. flush_count+1. Stay in RUN.
  2. mc_op=1: pc_write=0, if_id_write=0, id_ex_write=0. mc_cnt<=MC_CYCLES-2. Go to MC_BUSY.
  3. load_use=1: pc_write=0, if_id_write=0, id_ex_write=1, id_ex_bubble=1. Stay in RUN. The hazard clears the next cycle because ID/EX then holds a bubble, so the stall lasts exactly 1 cycle.
  4. Otherwise: all write enables are 1; flush and bubble are 0.
- MC_BUSY:
  - mc_busy=1. branch_taken, load_use and mc_op are ignored.
  - mc_cnt!=0: all write enables 0; mc_cnt decrements.
  - mc_cnt==0: all write enables 1, no flush or bubble; go to RUN.
  - The op therefore occupies EX for exactly MC_CYCLES cycles.
  - A multi-cycle op arriving immediately behind another re-enters MC_BUSY on the next RUN cycle. There is no skipped cycle and no merging.
- Counters:
  - stall_count increments on every cycle after reset with pc_write=0.
  - flush_count increments once per cycle with branch_taken accepted in RUN.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset mid-operation: asserting rst_n in MC_BUSY aborts immediately to the reset values. No pending count survives.
- All state updates occur on the rising edge of clk. Inputs are assumed to be stable before the edge.

Test Plan:
1. Reset and idle: rst_n=0 for 2 cycles, then release with no hazards. Required: forced reset outputs while low; afterwards pc_write=if_id_write=id_ex_write=1, flush=bubble=0, counters 0.
2. Load-use: ex_valid=1, ex_mem_read=1, ex_write_inst=1, ex_regC_adress=9, id_rt_adress=9, id_uses_rt=1. Required: exactly 1 cycle with pc_write=0, if_id_write=0, id_ex_bubble=1. Then with ex_valid=0, normal flow resumes; stall_count=1. Repeat with id_uses_rt=0: no stall.
3. Branch beats load-use: same hazard as scenario 2 plus branch_taken=1. Required: if_id_flush=1, id_ex_bubble=1, pc_write=1, no stall, flush_count=1, stall_count unchanged.
4. Multi-cycle: MC_CYCLES=4, ex_alu_op=24, ex_valid=1. Required: enables 0 for 3 cycles (mc_busy=1 on cycles 2-3); enables 1 on cycle 4; state RUN; stall_count=3. Back-to-back DIV (op 25): a second 4-cycle window immediately follows.
5. Reset mid-busy: assert rst_n=0 on the second MC_BUSY cycle. Required: mc_busy=0 and reset outputs immediately, without waiting for a clock edge. After release: RUN, counters 0.
6. Saturation: CNT_W=4, hold load_use with ex_valid=1 for 20 cycles. Required: stall_count stops at 15 and does not wrap.
